reorder_buffer: RTL and testbench

- Downstream stage fed by the dual-issue dispatch block. It accepts up to two robDispatchStruct entries per cycle.
- Marks entries complete from three forwarding/completion buses.
- Retires up to two entries per cycle in program order, head first.
- Drives retire ports to the free list (rd_old release) and the store-commit logic (MemWrite).

---
 rtl/reorder_buffer_pkg.sv | 66 ++++++
 rtl/reorder_buffer_retire_sel.sv | 22 ++
 rtl/reorder_buffer.sv | 195 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer and its retire selector.
package reorder_buffer_pkg;

  localparam int unsigned ROB_IDX_W = 4;
  localparam int unsigned ROB_DEPTH = 1 << ROB_IDX_W;
  localparam int unsigned RETIRE_W  = 2;

  typedef enum logic [1:0] {
    ROB_FREE,
    ROB_PENDING,
    ROB_DONE
  } robStateEnum;

  typedef struct packed {
    logic                 valid;
    logic [31:0]          pc;
    logic [4:0]           rd;
    logic [4:0]           rd_old;
    logic                 RegWrite;
    logic                 MemWrite;
    logic [ROB_IDX_W-1:0] robNum;
  } robDispatchStruct;

  typedef struct packed {
    logic                 valid;
    logic [4:0]           reg_addr;
    logic [31:0]          data;
    logic [ROB_IDX_W-1:0] robNum;
  } forwardingStruct;

  typedef struct packed {
    logic                 valid;
    logic [31:0]          pc;
    logic [4:0]           rd;
    logic [4:0]           rd_old;
    logic                 RegWrite;
    logic                 MemWrite;
    logic [ROB_IDX_W-1:0] robNum;
  } robRetireStruct;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rd_old;
    logic        RegWrite;
    logic        MemWrite;
  } rob_entry_t;

  function automatic logic [ROB_IDX_W-1:0] rob_inc(input logic [ROB_IDX_W-1:0] i);
    return i + ROB_IDX_W'(1);
  endfunction

  function automatic robRetireStruct make_retire(input rob_entry_t e,
                                                 input logic [ROB_IDX_W-1:0] n);
    robRetireStruct r;
    r.valid    = 1'b1;
    r.pc       = e.pc;
    r.rd       = e.rd;
    r.rd_old   = e.rd_old;
    r.RegWrite = e.RegWrite;
    r.MemWrite = e.MemWrite;
    r.robNum   = n;
    return r;
  endfunction

endpackage

// File: rtl/reorder_buffer_retire_sel.sv
// Head / head+1 DONE check: produces in-order retire valids and retire count.
module rob_retire_sel
  import reorder_buffer_pkg::*;
(
  input  logic [ROB_DEPTH-1:0] done_vec,
  input  logic [ROB_IDX_W-1:0] head,
  output logic [ROB_IDX_W-1:0] idx_a,
  output logic [ROB_IDX_W-1:0] idx_b,
  output logic                 ret_a,
  output logic                 ret_b,
  output logic [1:0]           ret_cnt
);

  always_comb begin
    idx_a   = head;
    idx_b   = rob_inc(head);
    ret_a   = done_vec[idx_a];
    ret_b   = ret_a & done_vec[idx_b];
    ret_cnt = {1'b0, ret_a} + {1'b0, ret_b};
  end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: dual dispatch, three completion buses, in-order dual retire.
// Define ROB_PERF_EN to add the perf_retired / perf_stall_cycles counters.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  robDispatchStruct     rob_dispatch_a,
  input  robDispatchStruct     rob_dispatch_b,
  input  forwardingStruct      complete_a,
  input  forwardingStruct      complete_b,
  input  forwardingStruct      complete_c,
  output robRetireStruct       retire_a,
  output robRetireStruct       retire_b,
  output logic                 rob_full,
  output logic                 rob_empty,
  output logic [ROB_IDX_W:0]   rob_count,
  output logic                 rob_error
`ifdef ROB_PERF_EN
  ,
  output logic [31:0]          perf_retired,
  output logic [31:0]          perf_stall_cycles
`endif
);

  robStateEnum          state_q [ROB_DEPTH];
  robStateEnum          state_d [ROB_DEPTH];
  rob_entry_t           entry_q [ROB_DEPTH];
  rob_entry_t           entry_d [ROB_DEPTH];
  logic [ROB_IDX_W-1:0] head_q, head_d;
  logic [ROB_IDX_W:0]   count_q, count_d;
  logic                 error_q, error_d;
  robRetireStruct       retire_a_q, retire_a_d;
  robRetireStruct       retire_b_q, retire_b_d;

  logic [ROB_DEPTH-1:0] done_vec;
  logic [ROB_IDX_W-1:0] idx_a, idx_b;
  logic                 ret_a, ret_b;
  logic [1:0]           ret_cnt;
  logic                 acc_a, acc_b;
  forwardingStruct      comp_bus [3];
  logic                 unused_comp_bits;

  assign comp_bus[0] = complete_a;
  assign comp_bus[1] = complete_b;
  assign comp_bus[2] = complete_c;
  assign unused_comp_bits = ^{complete_a.reg_addr, complete_a.data,
                              complete_b.reg_addr, complete_b.data,
                              complete_c.reg_addr, complete_c.data};

  always_comb begin
    done_vec = '0;
    for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
      done_vec[i] = (state_q[i] == ROB_DONE);
    end
  end

  rob_retire_sel u_retire_sel (
    .done_vec (done_vec),
    .head     (head_q),
    .idx_a    (idx_a),
    .idx_b    (idx_b),
    .ret_a    (ret_a),
    .ret_b    (ret_b),
    .ret_cnt  (ret_cnt)
  );

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    error_d    = error_q;
    retire_a_d = '0;
    retire_b_d = '0;
    acc_a      = 1'b0;
    acc_b      = 1'b0;
    head_d     = head_q + ROB_IDX_W'(ret_cnt);

    if (ret_a) begin
      retire_a_d     = make_retire(entry_q[idx_a], idx_a);
      state_d[idx_a] = ROB_FREE;
    end
    if (ret_b) begin
      retire_b_d     = make_retire(entry_q[idx_b], idx_b);
      state_d[idx_b] = ROB_FREE;
    end

    // Retiring slots are DONE, so a completion hitting one is already an error
    // and leaves the FREE written above intact.
    for (int unsigned c = 0; c < 3; c++) begin
      if (comp_bus[c].valid) begin
        if (state_q[comp_bus[c].robNum] == ROB_PENDING) begin
          state_d[comp_bus[c].robNum] = ROB_DONE;
        end else begin
          error_d = 1'b1;
        end
      end
    end

    // Dispatch is applied after completion so it overrides a same-slot completion.
    if (rob_dispatch_a.valid) begin
      if (state_q[rob_dispatch_a.robNum] == ROB_FREE) begin
        acc_a = 1'b1;
        state_d[rob_dispatch_a.robNum] = ROB_PENDING;
        entry_d[rob_dispatch_a.robNum] = '{pc:       rob_dispatch_a.pc,
                                           rd:       rob_dispatch_a.rd,
                                           rd_old:   rob_dispatch_a.rd_old,
                                           RegWrite: rob_dispatch_a.RegWrite,
                                           MemWrite: rob_dispatch_a.MemWrite};
      end else begin
        error_d = 1'b1;
      end
    end
    if (rob_dispatch_b.valid) begin
      if (state_q[rob_dispatch_b.robNum] == ROB_FREE &&
          !(acc_a && rob_dispatch_b.robNum == rob_dispatch_a.robNum)) begin
        acc_b = 1'b1;
        state_d[rob_dispatch_b.robNum] = ROB_PENDING;
        entry_d[rob_dispatch_b.robNum] = '{pc:       rob_dispatch_b.pc,
                                           rd:       rob_dispatch_b.rd,
                                           rd_old:   rob_dispatch_b.rd_old,
                                           RegWrite: rob_dispatch_b.RegWrite,
                                           MemWrite: rob_dispatch_b.MemWrite};
      end else begin
        error_d = 1'b1;
      end
    end
    if (rob_dispatch_a.valid && rob_dispatch_b.valid &&
        rob_dispatch_b.robNum != rob_inc(rob_dispatch_a.robNum)) begin
      error_d = 1'b1;
    end

    count_d = count_q + (ROB_IDX_W+1)'(acc_a) + (ROB_IDX_W+1)'(acc_b)
            - (ROB_IDX_W+1)'(ret_cnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      count_q    <= '0;
      error_q    <= 1'b0;
      retire_a_q <= '0;
      retire_b_q <= '0;
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        state_q[i] <= ROB_FREE;
      end
    end else begin
      head_q     <= head_d;
      count_q    <= count_d;
      error_q    <= error_d;
      retire_a_q <= retire_a_d;
      retire_b_q <= retire_b_d;
      state_q    <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  assign retire_a  = retire_a_q;
  assign retire_b  = retire_b_q;
  assign rob_count = count_q;
  assign rob_empty = (count_q == '0);
  assign rob_full  = (count_q >= (ROB_IDX_W+1)'(ROB_DEPTH - 1));
  assign rob_error = error_q;

`ifdef ROB_PERF_EN
  logic [31:0] perf_retired_q, perf_retired_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [32:0] retired_sum;

  always_comb begin
    retired_sum    = {1'b0, perf_retired_q} + 33'(ret_cnt);
    perf_retired_d = retired_sum[32] ? '1 : retired_sum[31:0];
    perf_stall_d   = perf_stall_q;
    if (rob_full && perf_stall_q != '1) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_retired_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_retired      = perf_retired_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: vector table plus retire scoreboard.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  robDispatchStruct   da, db;
  forwardingStruct    ca, cb, cc;
  robRetireStruct     retire_a, retire_b;
  logic               rob_full, rob_empty, rob_error;
  logic [ROB_IDX_W:0] rob_count;
`ifdef ROB_PERF_EN
  logic [31:0]        perf_retired, perf_stall_cycles;
`endif

  int errors = 0;
  int checks = 0;
  robDispatchStruct exp_q [$];

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .rob_dispatch_a (da),
    .rob_dispatch_b (db),
    .complete_a     (ca),
    .complete_b     (cb),
    .complete_c     (cc),
    .retire_a       (retire_a),
    .retire_b       (retire_b),
    .rob_full       (rob_full),
    .rob_empty      (rob_empty),
    .rob_count      (rob_count),
    .rob_error      (rob_error)
`ifdef ROB_PERF_EN
    ,
    .perf_retired      (perf_retired),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  typedef struct {
    logic       dav; logic [3:0] dan;
    logic       dbv; logic [3:0] dbn;
    logic       cav; logic [3:0] can;
    logic       cbv; logic [3:0] cbn;
    logic [4:0] cnt;
    logic       full, empty, err, ra, rb;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // robNum 7 is always a store: no destination register, explicit completion.
  function automatic robDispatchStruct mk_disp(input logic v, input logic [3:0] n);
    robDispatchStruct d;
    d = '0;
    if (v) begin
      d.valid  = 1'b1;
      d.robNum = n;
      d.pc     = 32'h100 + 32'(n) * 32'd4;
      if (n == 4'd7) begin
        d.MemWrite = 1'b1;
      end else begin
        d.RegWrite = 1'b1;
        d.rd       = 5'(n) + 5'd5;
        d.rd_old   = 5'(n) + 5'd2;
      end
    end
    return d;
  endfunction

  function automatic forwardingStruct mk_comp(input logic v, input logic [3:0] n);
    forwardingStruct f;
    f = '0;
    if (v) begin
      f.valid    = 1'b1;
      f.robNum   = n;
      f.reg_addr = 5'(n);
      f.data     = 32'hC0DE_0000 + 32'(n);
    end
    return f;
  endfunction

  task automatic sb_check(input string name, input robRetireStruct r);
    robDispatchStruct e;
    if (exp_q.size() == 0) begin
      chk({name, ".unexpected"}, 32'(r.robNum), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      chk({name, ".robNum"}, 32'(r.robNum), 32'(e.robNum));
      chk({name, ".pc"}, r.pc, e.pc);
      chk({name, ".rd_rdold"}, {22'd0, r.rd, r.rd_old}, {22'd0, e.rd, e.rd_old});
      chk({name, ".ctl"}, {30'd0, r.RegWrite, r.MemWrite}, {30'd0, e.RegWrite, e.MemWrite});
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (retire_a.valid === 1'b1) sb_check("retire_a", retire_a);
    if (retire_b.valid === 1'b1) begin
      chk("retire_b_needs_a", 32'(retire_a.valid), 32'd1);
      sb_check("retire_b", retire_b);
    end
  end

  task automatic set_idle();
    da = '0; db = '0; ca = '0; cb = '0; cc = '0;
  endtask

  task automatic cycle_in(input logic dav, input logic [3:0] dan,
                          input logic dbv, input logic [3:0] dbn,
                          input logic cav, input logic [3:0] can,
                          input logic cbv, input logic [3:0] cbn,
                          input logic ccv, input logic [3:0] ccn,
                          input logic push);
    da = mk_disp(dav, dan);
    db = mk_disp(dbv, dbn);
    ca = mk_comp(cav, can);
    cb = mk_comp(cbv, cbn);
    cc = mk_comp(ccv, ccn);
    if (push && dav) exp_q.push_back(mk_disp(1'b1, dan));
    if (push && dbv) exp_q.push_back(mk_disp(1'b1, dbn));
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic dispatch_seq(input int start, input int n);
    for (int i = 0; i < n; i += 2) begin
      if (i + 1 < n) cycle_in(1, 4'(start + i), 1, 4'(start + i + 1), 0, 0, 0, 0, 0, 0, 1);
      else           cycle_in(1, 4'(start + i), 0, 0, 0, 0, 0, 0, 0, 0, 1);
    end
  endtask

  task automatic complete_seq(input int start, input int n);
    for (int i = 0; i < n; i += 3) begin
      cycle_in(0, 0, 0, 0,
               1'(i < n), 4'(start + i),
               1'(i + 1 < n), 4'(start + i + 1),
               1'(i + 2 < n), 4'(start + i + 2), 0);
    end
  endtask

  task automatic wait_empty(input string name, input int budget);
    int k = 0;
    while (rob_empty !== 1'b1 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(name, 32'(rob_empty), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_idle();
    @(posedge clk);
    #1;
    exp_q.delete();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 0, 1, 1, 0, 0, 0, 0, 5'd2, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 1, 1, 0, 0, 5'd2, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 0, 0, 0, 1, 0, 5'd2, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 1, 1};
    tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 0};
    for (int p = 0; p < 8; p++) begin
      tbl[5 + p] = '{1, 4'(2 + 2 * p), 1, 4'(3 + 2 * p), 0, 0, 0, 0,
                     5'(2 * (p + 1)), 1'(p == 7), 0, 0, 0, 0};
    end

    reset = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset.count", 32'(rob_count), 32'd0);
    chk("reset.empty", 32'(rob_empty), 32'd1);
    chk("reset.full", 32'(rob_full), 32'd0);
    chk("reset.error", 32'(rob_error), 32'd0);
    chk("reset.retire_a", 32'(retire_a.valid), 32'd0);
    chk("reset.retire_b", 32'(retire_b.valid), 32'd0);

    for (int unsigned r = 0; r < 13; r++) begin
      cycle_in(tbl[r].dav, tbl[r].dan, tbl[r].dbv, tbl[r].dbn,
               tbl[r].cav, tbl[r].can, tbl[r].cbv, tbl[r].cbn, 0, 0, 1);
      chk($sformatf("row%0d.count", r), 32'(rob_count), 32'(tbl[r].cnt));
      chk($sformatf("row%0d.full", r), 32'(rob_full), 32'(tbl[r].full));
      chk($sformatf("row%0d.empty", r), 32'(rob_empty), 32'(tbl[r].empty));
      chk($sformatf("row%0d.error", r), 32'(rob_error), 32'(tbl[r].err));
      chk($sformatf("row%0d.ret_a", r), 32'(retire_a.valid), 32'(tbl[r].ra));
      chk($sformatf("row%0d.ret_b", r), 32'(retire_b.valid), 32'(tbl[r].rb));
    end

    // Drain the full buffer (head at 2), then advance head to 15.
    complete_seq(2, 16);
    wait_empty("drain.empty", 20);
    dispatch_seq(2, 13);
    complete_seq(2, 13);
    wait_empty("prewrap.empty", 20);

    cycle_in(1, 15, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle_in(0, 0, 0, 0, 1, 15, 1, 0, 0, 0, 0);
    idle(1);
    chk("wrap.ret_a", 32'(retire_a.valid), 32'd1);
    chk("wrap.ret_b", 32'(retire_b.valid), 32'd1);
    chk("wrap.count", 32'(rob_count), 32'd0);
    cycle_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle_in(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    idle(1);
    chk("head1.ret_a", 32'(retire_a.valid), 32'd1);
    chk("head1.count", 32'(rob_count), 32'd0);
    chk("head1.error", 32'(rob_error), 32'd0);

    cycle_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    chk("freecomp.error", 32'(rob_error), 32'd1);
    chk("freecomp.count", 32'(rob_count), 32'd0);
    chk("freecomp.empty", 32'(rob_empty), 32'd1);
    idle(3);
    chk("freecomp.sticky", 32'(rob_error), 32'd1);

    // Mid-operation reset with 6 pending entries and a retire on the outputs.
    do_reset();
    dispatch_seq(0, 8);
    cycle_in(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    idle(1);
    chk("prereset.ret_a", 32'(retire_a.valid), 32'd1);
    chk("prereset.count", 32'(rob_count), 32'd6);
    reset = 1'b1;
    da = mk_disp(1, 8);
    ca = mk_comp(1, 2);
    @(posedge clk);
    #1;
    exp_q.delete();
    reset = 1'b0;
    set_idle();
    chk("midreset.count", 32'(rob_count), 32'd0);
    chk("midreset.ret_a", 32'(retire_a.valid), 32'd0);
    chk("midreset.ret_b", 32'(retire_b.valid), 32'd0);
    chk("midreset.empty", 32'(rob_empty), 32'd1);
    chk("midreset.full", 32'(rob_full), 32'd0);
    chk("midreset.error", 32'(rob_error), 32'd0);
    cycle_in(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    chk("postreset_comp3.error", 32'(rob_error), 32'd1);
    idle(2);
    chk("postreset.no_retire", 32'(retire_a.valid), 32'd0);

    // Dispatch onto an occupied slot is dropped; original entry still retires.
    do_reset();
    cycle_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("dupdisp.count", 32'(rob_count), 32'd1);
    chk("dupdisp.error", 32'(rob_error), 32'd1);
    cycle_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    wait_empty("dupdisp.drain", 10);

`ifdef ROB_PERF_EN
    do_reset();
    chk("perf.reset_ret", perf_retired, 32'd0);
    chk("perf.reset_stall", perf_stall_cycles, 32'd0);
    dispatch_seq(0, 16);
    idle(3);
    chk("perf.stall3", perf_stall_cycles, 32'd3);
    do_reset();
    dispatch_seq(0, 10);
    for (int k = 0; k < 5; k++) begin
      cycle_in(0, 0, 0, 0, 1, 4'(2 * k), 1, 4'(2 * k + 1), 0, 0, 0);
    end
    wait_empty("perf.drain", 10);
    chk("perf.retired10", perf_retired, 32'd10);
`endif

    idle(2);
    chk("sb.leftover", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
